// File: rtl/edge_dff.sv
// Negative-edge D flip-flop built from two feedback-assign latches, with synchronous active-low clear.
// Optional load enable input 'en' is present when EDGE_DFF_LOAD_EN is defined.
module edge_dff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             clear,
`ifdef EDGE_DFF_LOAD_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] d_int;
    logic [WIDTH-1:0] master;
    logic [WIDTH-1:0] slave;

    // Clear gates the data ahead of the master latch, so it only acts at a falling edge.
`ifdef EDGE_DFF_LOAD_EN
    assign d_int = !clear ? '0 : (en ? d : slave);
`else
    assign d_int = clear ? d : '0;
`endif

    // Master is open while clk is high; slave is open while clk is low.
    assign master = clk ? d_int : master;
    assign slave  = clk ? slave : master;

    assign q    = slave;
    assign qbar = ~slave;

endmodule

// File: tb/tb_edge_dff.sv
// Directed self-checking bench for edge_dff: reset, loads, glitch immunity and clear timing.
// Clock period 100; falling edges at 50 + 100*k, rising edges at 100*k.
module tb_edge_dff;

    localparam int unsigned W = 4;

    logic         clk;
    logic         clear;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
`ifdef EDGE_DFF_LOAD_EN
    logic         en;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    edge_dff #(.WIDTH(W)) dut (
        .clk   (clk),
        .clear (clear),
`ifdef EDGE_DFF_LOAD_EN
        .en    (en),
`endif
        .d     (d),
        .q     (q),
        .qbar  (qbar)
    );

    initial begin
        clk = 1'b1;
        forever #50 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of test, expected finish before 100000");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [W-1:0] exp);
        n_checks++;
        assert (q === exp) else begin
            n_fail++;
            $error("FAIL %s q: observed %h expected %h", tag, q, exp);
        end
        n_checks++;
        assert (qbar === ~exp) else begin
            n_fail++;
            $error("FAIL %s qbar: observed %h expected %h", tag, qbar, ~exp);
        end
    endtask

    initial begin
        clear = 1'b0;
        d     = '0;
`ifdef EDGE_DFF_LOAD_EN
        en    = 1'b1;
`endif
        // Reset
        @(negedge clk); #1;
        check("reset", 4'h0);
        clear = 1'b1;
        @(posedge clk); #1;
        check("reset_hold_rise", 4'h0);

        // Load all ones: not at the rising edge, only at the falling edge
        d = 4'hF;
        #10;
        check("load1_before_fall", 4'h0);
        @(negedge clk); #1;
        check("load1_fall", 4'hF);
        @(posedge clk); #1;
        check("load1_rise", 4'hF);
        @(negedge clk); #1;
        check("load1_hold_a", 4'hF);
        @(negedge clk); #1;
        check("load1_hold_b", 4'hF);

        // Independent bits
        @(posedge clk); #1;
        d = 4'hA;
        @(negedge clk); #1;
        check("load_a", 4'hA);
        @(posedge clk); #1;
        d = 4'h5;
        check("load_5_before", 4'hA);
        @(negedge clk); #1;
        check("load_5", 4'h5);

        // Load 0
        @(posedge clk); #1;
        d = 4'h0;
        check("load0_rise", 4'h5);
        @(negedge clk); #1;
        check("load0_fall", 4'h0);

        // Glitches while clk high, base 0
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            #2 d = ~d;
        end
        @(negedge clk); #1;
        check("glitch_hi_0", 4'h0);

        // Glitches while clk high, base 1
        d = 4'hF;
        @(negedge clk); #1;
        check("glitch_hi_1_setup", 4'hF);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            #2 d = ~d;
        end
        @(negedge clk); #1;
        check("glitch_hi_1", 4'hF);

        // Glitches while clk low, base 1 (we are 1 unit after a falling edge)
        for (int i = 0; i < 20; i++) begin
            #2 d = ~d;
            check("glitch_lo_1_pulse", 4'hF);
        end
        @(posedge clk); #1;
        check("glitch_lo_1_rise", 4'hF);

        // Glitches while clk low, base 0
        d = 4'h0;
        @(negedge clk); #1;
        check("glitch_lo_0_setup", 4'h0);
        for (int i = 0; i < 20; i++) begin
            #2 d = ~d;
            check("glitch_lo_0_pulse", 4'h0);
        end
        @(posedge clk); #1;
        check("glitch_lo_0_rise", 4'h0);

        // Clear pulse confined to clk-high phase has no effect
        d = 4'hF;
        @(negedge clk); #1;
        check("clr_setup", 4'hF);
        @(posedge clk); #5;
        clear = 1'b0;
        #20;
        check("clr_pulse_hi_mid", 4'hF);
        clear = 1'b1;
        @(negedge clk); #1;
        check("clr_pulse_hi", 4'hF);

        // Clear pulse confined to clk-low phase has no effect
        #4;
        clear = 1'b0;
        #20;
        check("clr_pulse_lo_mid", 4'hF);
        clear = 1'b1;
        @(negedge clk); #1;
        check("clr_pulse_lo", 4'hF);

        // Clear spanning a falling edge clears exactly at that edge
        @(posedge clk); #30;
        clear = 1'b0;
        #19;
        check("clr_span_before", 4'hF);
        @(negedge clk); #1;
        check("clr_span_edge", 4'h0);
        #9;
        clear = 1'b1;
        @(posedge clk); #1;
        check("clr_release_rise", 4'h0);
        @(negedge clk); #1;
        check("clr_release_fall", 4'hF);

`ifdef EDGE_DFF_LOAD_EN
        // Clear dominates en=0
        en    = 1'b0;
        clear = 1'b0;
        @(negedge clk); #1;
        check("en0_clear", 4'h0);
        clear = 1'b1;
        d     = 4'hF;
        @(negedge clk); #1;
        check("en0_hold_a", 4'h0);
        @(negedge clk); #1;
        check("en0_hold_b", 4'h0);
        en = 1'b1;
        @(negedge clk); #1;
        check("en1_load", 4'hF);
        en = 1'b0;
        d  = 4'h3;
        @(negedge clk); #1;
        check("en0_hold_f", 4'hF);
        en = 1'b1;
        @(negedge clk); #1;
        check("en1_load_3", 4'h3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
